// File: rtl/vx_raster_packer_pkg.sv
// rtl/vx_raster_packer_pkg.sv - stamp layout and FSM states for the raster stamp bus
package vx_raster_packer_pkg;

  localparam int POS_BITS    = 12;
  localparam int MASK_BITS   = 4;
  localparam int PID_BITS    = 8;
  localparam int BCOORD_BITS = 8;

  typedef struct packed {
    logic [POS_BITS-1:0]         pos_x;
    logic [POS_BITS-1:0]         pos_y;
    logic [MASK_BITS-1:0]        mask;
    logic [PID_BITS-1:0]         pid;
    logic [2:0][BCOORD_BITS-1:0] bcoords;
  } raster_stamp_t;

  localparam int STAMP_BITS = $bits(raster_stamp_t);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } packer_state_e;

endpackage

// File: rtl/vx_raster_packer.sv
// rtl/vx_raster_packer.sv - packs backend stamps into NUM_LANES-wide raster bus requests
module vx_raster_packer
  import vx_raster_packer_pkg::*;
#(
  parameter int NUM_LANES    = 1,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [STAMP_BITS-1:0]           in_data,
  output logic                            in_ready,
  input  logic                            in_done,
  input  logic                            frame_start,
  output logic                            req_valid,
  output logic [NUM_LANES*STAMP_BITS-1:0] req_data_stamps,
  output logic                            req_data_done,
  input  logic                            req_ready
);

  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LANES_FULL = CNT_W'(NUM_LANES);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(FLUSH_CYCLES);

  packer_state_e                 state_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d, wr_lane;
  logic [IDLE_W-1:0]             idle_q, idle_d;
  raster_stamp_t [NUM_LANES-1:0] acc_q;
  raster_stamp_t [NUM_LANES-1:0] slot_q;
  logic                          req_valid_q, req_done_q;
  logic                          filling, slot_free, xfer, in_fire, enter_done;

  always_comb begin
    filling    = (state_q == ST_FILL);
    slot_free  = !req_valid_q || req_ready;
    xfer       = filling && slot_free &&
                 ((cnt_q == LANES_FULL) ||
                  (cnt_q != '0 && idle_q == IDLE_MAX) ||
                  (cnt_q != '0 && in_done && !in_valid));
    // A transfer frees lane 0 on the same edge, so a full accumulator can still accept.
    in_ready   = filling && ((cnt_q < LANES_FULL) || xfer);
    in_fire    = in_valid && in_ready;
    enter_done = filling && in_done && !in_valid && (cnt_q == '0) && slot_free;
    wr_lane    = xfer ? '0 : cnt_q;
    cnt_d      = in_fire ? wr_lane + CNT_W'(1) : wr_lane;
    idle_d     = idle_q;
    if (in_fire || xfer) begin
      idle_d = '0;
    end else if (filling && cnt_q != '0 && idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      idle_q      <= '0;
      req_valid_q <= 1'b0;
      req_done_q  <= 1'b0;
      slot_q      <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          cnt_q  <= cnt_d;
          idle_q <= idle_d;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (in_fire && CNT_W'(i) == wr_lane) acc_q[i] <= in_data;
          end
          if (xfer) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              slot_q[i] <= (CNT_W'(i) < cnt_q) ? acc_q[i] : '0;
            end
            req_done_q  <= 1'b0;
            req_valid_q <= 1'b1;
          end else if (enter_done) begin
            slot_q      <= '0;
            req_done_q  <= 1'b1;
            req_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (req_ready) begin
            req_valid_q <= 1'b0;
          end
        end
        ST_DONE: begin
          // The done packet is replayed on every handshake until the next frame re-arms us.
          if (frame_start) begin
            state_q     <= ST_FILL;
            req_valid_q <= 1'b0;
            req_done_q  <= 1'b0;
            cnt_q       <= '0;
            idle_q      <= '0;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign req_valid       = req_valid_q;
  assign req_data_stamps = slot_q;
  assign req_data_done   = req_done_q;

endmodule
